cmp_search_8_bit: RTL and testbench

CMP_SEARCH_8_BIT -- requirements
Module: cmp_search_8_bit

---
 rtl/cmp_search_8_bit.sv | 155 +++++++++++++++
 tb/tb_cmp_search_8_bit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_8_bit.sv
// Binary-search initiator that drives an external comparator responder to locate a hidden value.
// Optional feature: define CMP_SEARCH_ERRCHK_EN to flag responses that are not one-hot on eq/gt/lt.
module cmp_search_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       iter_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Bounds carry one extra magnitude bit plus a sign bit so hi can reach -1 and lo can reach 2^WIDTH.
    localparam logic signed [WIDTH+1:0] HI_INIT = {2'b00, {WIDTH{1'b1}}};
    localparam logic signed [WIDTH+1:0] ONE     = {{(WIDTH+1){1'b0}}, 1'b1};

    state_t                  state;
    logic signed [WIDTH+1:0] lo;
    logic signed [WIDTH+1:0] hi;
    logic signed [WIDTH+1:0] trialExt;
    logic signed [WIDTH+1:0] nextLo;
    logic signed [WIDTH+1:0] nextHi;
    logic                    exhausted;
    logic                    respEq;
    logic                    respGt;
    logic                    respLt;
`ifdef CMP_SEARCH_ERRCHK_EN
    logic                    respBad;
`endif

    function automatic logic [WIDTH-1:0] midPoint(input logic signed [WIDTH+1:0] a,
                                                  input logic signed [WIDTH+1:0] b);
        logic signed [WIDTH+1:0] sum;
        sum = a + b;
        return sum[WIDTH:1];
    endfunction

    function automatic logic [3:0] satInc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    always_comb begin
        trialExt  = signed'({2'b00, trial});
        respEq    = cmp_eq;
        respGt    = ~cmp_eq & cmp_gt;
        // An explicit lt, or no flag at all, both narrow the upper bound.
        respLt    = ~cmp_eq & ~cmp_gt & (cmp_lt | ~(cmp_eq | cmp_gt | cmp_lt));
`ifdef CMP_SEARCH_ERRCHK_EN
        respBad   = ~(cmp_eq ^ cmp_gt ^ cmp_lt) | (cmp_eq & cmp_gt & cmp_lt);
`endif
        nextLo    = respGt ? trialExt + ONE : lo;
        nextHi    = respLt ? trialExt - ONE : hi;
        exhausted = nextLo > nextHi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            trial       <= '0;
            trial_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            result      <= '0;
            iter_cnt    <= '0;
`ifdef CMP_SEARCH_ERRCHK_EN
            err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lo          <= '0;
                        hi          <= HI_INIT;
                        iter_cnt    <= '0;
                        found       <= 1'b0;
`ifdef CMP_SEARCH_ERRCHK_EN
                        err         <= 1'b0;
`endif
                        trial       <= midPoint('0, HI_INIT);
                        trial_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    trial_valid <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cmp_valid) begin
                        iter_cnt <= satInc(iter_cnt);
`ifdef CMP_SEARCH_ERRCHK_EN
                        if (respBad) begin
                            err    <= 1'b1;
                            found  <= 1'b0;
                            result <= trial;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else
`endif
                        if (respEq) begin
                            found  <= 1'b1;
                            result <= trial;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            lo <= nextLo;
                            hi <= nextHi;
                            if (exhausted) begin
                                found  <= 1'b0;
                                result <= trial;
                                done   <= 1'b1;
                                state  <= DONE;
                            end else begin
                                trial       <= midPoint(nextLo, nextHi);
                                trial_valid <= 1'b1;
                                state       <= ISSUE;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CMP_SEARCH_ERRCHK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_search_8_bit.sv
// Self-checking bench for cmp_search_8_bit: directed and random searches against an integer search model.
module tb_cmp_search_8_bit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cmp_valid;
    logic         cmp_eq;
    logic         cmp_gt;
    logic         cmp_lt;
    logic [W-1:0] trial;
    logic         trial_valid;
    logic         busy;
    logic         done;
    logic         found;
    logic [W-1:0] result;
    logic [3:0]   iter_cnt;
    logic         err;

    int errors = 0;
    int checks = 0;
    int expQ[$];
    int expFound;
    int expResult;
    int expIter;
    int expErr;

    always #5 clk = ~clk;

    cmp_search_8_bit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp_valid(cmp_valid),
        .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .trial(trial), .trial_valid(trial_valid), .busy(busy), .done(done),
        .found(found), .result(result), .iter_cnt(iter_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Responder behaviour: 0=eq, 1=gt, 2=lt, 3=gt and lt together (malformed)
    function automatic int respCode(input int a, input int t, input int mode, input int n);
        if (mode == 1) return 1;
        if (mode == 2 && n == 0) return 3;
        if (a == t) return 0;
        return (a > t) ? 1 : 2;
    endfunction

    // Expected trial sequence and outcome from plain interval bisection over integers
    task automatic model(input int a, input int mode);
        int lo, hi, t, n, r;
        expQ.delete();
        lo = 0;
        hi = (1 << W) - 1;
        n = 0;
        expErr = 0;
        forever begin
            t = (lo + hi) / 2;
            expQ.push_back(t);
            r = respCode(a, t, mode, n);
            n++;
            if (r == 3) begin
`ifdef CMP_SEARCH_ERRCHK_EN
                expErr = 1; expFound = 0; expResult = t;
                break;
`else
                r = 1;
`endif
            end
            if (r == 0) begin
                expFound = 1; expResult = t;
                break;
            end
            if (r == 1) lo = t + 1;
            else        hi = t - 1;
            if (lo > hi) begin
                expFound = 0; expResult = t;
                break;
            end
        end
        expIter = (n > 15) ? 15 : n;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_trial"}, trial, 0);
        chk({tag, "_tvalid"}, trial_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_iter"}, iter_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic runSearch(input int a, input int delay, input int mode, input bit poke,
                             input int abortAfter);
        int r;
        model(a, mode);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
        for (int i = 0; i < expQ.size(); i++) begin
            chk("trial_valid", trial_valid, 1);
            chk("trial", trial, expQ[i]);
            @(negedge clk);
            for (int d = 0; d < delay; d++) begin
                chk("tvalid_low", trial_valid, 0);
                chk("trial_hold", trial, expQ[i]);
                if (poke) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            chk("trial_hold", trial, expQ[i]);
            r = respCode(a, expQ[i], mode, i);
            cmp_valid = 1'b1;
            cmp_eq = (r == 0);
            cmp_gt = (r == 1 || r == 3);
            cmp_lt = (r == 2 || r == 3);
            @(negedge clk);
            cmp_valid = 1'b0;
            cmp_eq = 1'($urandom_range(0, 1));
            cmp_gt = 1'($urandom_range(0, 1));
            cmp_lt = 1'($urandom_range(0, 1));
            if (abortAfter == i + 1) begin
                @(negedge clk);
                return;
            end
            if (i + 1 < expQ.size()) chk("done_early", done, 0);
        end
        chk("done", done, 1);
        chk("found", found, expFound);
        chk("result", result, expResult);
        chk("iter_cnt", iter_cnt, expIter);
        chk("err", err, expErr);
        chk("busy_done", busy, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("found_hold", found, expFound);
        chk("result_hold", result, expResult);
        chk("iter_hold", iter_cnt, expIter);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cmp_valid = 1'b0;
        cmp_eq = 1'b0;
        cmp_gt = 1'b0;
        cmp_lt = 1'b0;
        repeat (3) @(negedge clk);
        chkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        runSearch(100, 0, 0, 1'b0, 0);
        runSearch(255, 0, 0, 1'b0, 0);
        runSearch(0, 2, 0, 1'b0, 0);
        runSearch(0, 0, 1, 1'b0, 0);
        runSearch(100, 5, 0, 1'b1, 0);
        runSearch(200, 1, 2, 1'b0, 0);

        runSearch(100, 0, 0, 1'b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chkAllZero("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_nodone", done, 0);
        runSearch(37, 0, 0, 1'b0, 0);

        repeat (20) begin
            runSearch(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 0,
                      1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
